// File: rtl/elevator_pkg.sv
// Shared encodings for the elevator car plant: landing count, motor commands,
// fault codes and car FSM states.
package elevator_pkg;

    localparam int unsigned FLOORS = 6;

    localparam logic [1:0] AC_IDLE    = 2'b00;
    localparam logic [1:0] AC_UP      = 2'b01;
    localparam logic [1:0] AC_DOWN    = 2'b10;
    localparam logic [1:0] AC_ILLEGAL = 2'b11;

    localparam logic [2:0] FLT_NONE       = 3'd0;
    localparam logic [2:0] FLT_DOOR       = 3'd1;
    localparam logic [2:0] FLT_ILLEGAL    = 3'd2;
    localparam logic [2:0] FLT_OVERTRAVEL = 3'd3;
    localparam logic [2:0] FLT_REVERSAL   = 3'd4;

    localparam logic [2:0] ST_STOP   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_RUN_UP = 3'd2;
    localparam logic [2:0] ST_RUN_DN = 3'd3;
    localparam logic [2:0] ST_FAULT  = 3'd4;

endpackage

// File: rtl/floor_zone_decode.sv
// Maps the car position (landing below + ticks above it) to one-hot landing
// sensors; a sensor is lit only within ZONE ticks of its landing.
module floor_zone_decode
    import elevator_pkg::*;
#(
    parameter int unsigned TRAVEL_TICKS = 20,
    parameter int unsigned ZONE = 2,
    localparam int unsigned OFF_W = $clog2(TRAVEL_TICKS)
) (
    input  logic [2:0]        floor_idx,
    input  logic [OFF_W-1:0]  offset,
    output logic [FLOORS-1:0] sensors
);

    localparam logic [OFF_W-1:0] ZONE_LO   = OFF_W'(ZONE);
    localparam logic [OFF_W-1:0] ZONE_HI   = OFF_W'(TRAVEL_TICKS - ZONE);
    localparam logic [2:0]       TOP_FLOOR = 3'(FLOORS - 1);

    always_comb begin
        sensors = '0;
        if (offset <= ZONE_LO) begin
            sensors = FLOORS'(1) << floor_idx;
        end else if (offset >= ZONE_HI && floor_idx < TOP_FLOOR) begin
            sensors = FLOORS'(2) << floor_idx;
        end
    end

endmodule

// File: rtl/elevator_car_model.sv
// Cycle-based hoistway/car plant: turns motor commands into car position and
// landing sensors, with motor spin-up and latched safety faults.
module elevator_car_model
    import elevator_pkg::*;
#(
    parameter int unsigned TRAVEL_TICKS = 20,
    parameter int unsigned ZONE = 2,
    parameter int unsigned START_TICKS = 2,
    parameter int unsigned OT_LIMIT = 4,
    localparam int unsigned OFF_W = $clog2(TRAVEL_TICKS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        ac,
    input  logic              open,
    input  logic              fault_clr,
    output logic [FLOORS-1:0] sensors,
    output logic [2:0]        floor_idx,
    output logic [OFF_W-1:0]  offset,
    output logic              moving,
    output logic              fault,
    output logic [2:0]        fault_code
);

    localparam int unsigned CNT_W = (START_TICKS > 1) ? $clog2(START_TICKS) : 1;
    localparam int unsigned OT_W  = $clog2(OT_LIMIT + 1);

    localparam logic [OFF_W-1:0] OFF_MAX   = OFF_W'(TRAVEL_TICKS - 1);
    localparam logic [2:0]       TOP_FLOOR = 3'(FLOORS - 1);
    localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(START_TICKS - 1);
    localparam logic [OT_W-1:0]  OT_MAX    = OT_W'(OT_LIMIT);

    logic [2:0]       state_q, state_d;
    logic [1:0]       dir_q, dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       floor_q, floor_d;
    logic [OFF_W-1:0] off_q, off_d;
    logic [OT_W-1:0]  ot_q, ot_d;
    logic             fault_q, fault_d;
    logic [2:0]       code_q, code_d;

    logic            hold_up, hold_dn, reversal;
    logic [OT_W-1:0] ot_inc;
    logic [2:0]      detect;

    // Fault detection, evaluated against the command arriving this cycle.
    always_comb begin
        hold_up  = state_q == ST_RUN_UP && ac == AC_UP
                   && floor_q == TOP_FLOOR && off_q == '0;
        hold_dn  = state_q == ST_RUN_DN && ac == AC_DOWN
                   && floor_q == 3'd0 && off_q == '0;
        reversal = (state_q == ST_RUN_UP && ac == AC_DOWN)
                   || (state_q == ST_RUN_DN && ac == AC_UP);
        ot_inc   = ot_q + OT_W'(1);

        if (ac == AC_ILLEGAL) begin
            detect = FLT_ILLEGAL;
        end else if (open && ac != AC_IDLE) begin
            detect = FLT_DOOR;
        end else if ((hold_up || hold_dn) && ot_inc >= OT_MAX) begin
            detect = FLT_OVERTRAVEL;
        end else if (reversal) begin
            detect = FLT_REVERSAL;
        end else begin
            detect = FLT_NONE;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        floor_d = floor_q;
        off_d   = off_q;
        ot_d    = '0;
        fault_d = fault_q;
        code_d  = code_q;

        if (state_q == ST_FAULT) begin
            if (fault_clr && ac == AC_IDLE) begin
                state_d = ST_STOP;
                fault_d = 1'b0;
                code_d  = FLT_NONE;
            end
        end else if (detect != FLT_NONE) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
            code_d  = detect;
        end else begin
            case (state_q)
                ST_STOP: begin
                    if (ac == AC_UP || ac == AC_DOWN) begin
                        state_d = ST_START;
                        dir_d   = ac;
                        cnt_d   = CNT_INIT;
                    end
                end
                ST_START: begin
                    // Dropping or flipping the command during spin-up just aborts it.
                    if (ac != dir_q) begin
                        state_d = ST_STOP;
                    end else if (cnt_q == '0) begin
                        state_d = (dir_q == AC_UP) ? ST_RUN_UP : ST_RUN_DN;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_RUN_UP: begin
                    if (ac == AC_IDLE) begin
                        state_d = ST_STOP;
                    end else if (hold_up) begin
                        ot_d = ot_inc;
                    end else if (off_q == OFF_MAX) begin
                        floor_d = floor_q + 3'd1;
                        off_d   = '0;
                    end else begin
                        off_d = off_q + OFF_W'(1);
                    end
                end
                ST_RUN_DN: begin
                    if (ac == AC_IDLE) begin
                        state_d = ST_STOP;
                    end else if (hold_dn) begin
                        ot_d = ot_inc;
                    end else if (off_q != '0) begin
                        off_d = off_q - OFF_W'(1);
                    end else begin
                        floor_d = floor_q - 3'd1;
                        off_d   = OFF_MAX;
                    end
                end
                default: state_d = ST_STOP;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_STOP;
            dir_q   <= AC_IDLE;
            cnt_q   <= '0;
            floor_q <= 3'd0;
            off_q   <= '0;
            ot_q    <= '0;
            fault_q <= 1'b0;
            code_q  <= FLT_NONE;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            floor_q <= floor_d;
            off_q   <= off_d;
            ot_q    <= ot_d;
            fault_q <= fault_d;
            code_q  <= code_d;
        end
    end

    floor_zone_decode #(
        .TRAVEL_TICKS(TRAVEL_TICKS),
        .ZONE        (ZONE)
    ) u_zone (
        .floor_idx(floor_q),
        .offset   (off_q),
        .sensors  (sensors)
    );

    assign floor_idx  = floor_q;
    assign offset     = off_q;
    assign moving     = state_q == ST_RUN_UP || state_q == ST_RUN_DN;
    assign fault      = fault_q;
    assign fault_code = code_q;

endmodule

// File: tb/tb_elevator_car_model.sv
// Self-checking bench for elevator_car_model: directed scenarios then random
// commands, compared against an absolute-position reference model.
module tb_elevator_car_model;

    localparam int T   = 20;
    localparam int Z   = 2;
    localparam int ST  = 2;
    localparam int OTL = 4;
    localparam int NF  = 6;
    localparam int MAXPOS = (NF - 1) * T;

    localparam int M_IDLE = 0;
    localparam int M_SPIN = 1;
    localparam int M_RUN  = 2;
    localparam int M_FLT  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] ac;
    logic       open;
    logic       fault_clr;
    logic [5:0] sensors;
    logic [2:0] floor_idx;
    logic [4:0] offset;
    logic       moving;
    logic       fault;
    logic [2:0] fault_code;

    int checks = 0;
    int errors = 0;

    // Reference model: car position as absolute ticks above landing 0.
    int m_mode, m_dir, m_spin, m_pos, m_hold, m_code;

    elevator_car_model #(
        .TRAVEL_TICKS(T),
        .ZONE        (Z),
        .START_TICKS (ST),
        .OT_LIMIT    (OTL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ac        (ac),
        .open      (open),
        .fault_clr (fault_clr),
        .sensors   (sensors),
        .floor_idx (floor_idx),
        .offset    (offset),
        .moving    (moving),
        .fault     (fault),
        .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode = M_IDLE;
        m_dir  = 0;
        m_spin = 0;
        m_pos  = 0;
        m_hold = 0;
        m_code = 0;
    endtask

    task automatic model_step(input logic [1:0] a, input logic op, input logic clr);
        int cmd;
        int code;
        int prev_hold;
        bit at_end;
        cmd = (a == 2'b01) ? 1 : (a == 2'b10) ? -1 : 0;
        prev_hold = m_hold;
        m_hold = 0;
        if (m_mode == M_FLT) begin
            if (clr && a == 2'b00) begin
                m_mode = M_IDLE;
                m_code = 0;
            end
            return;
        end
        at_end = m_mode == M_RUN && cmd == m_dir && cmd != 0
                 && ((m_dir > 0 && m_pos == MAXPOS) || (m_dir < 0 && m_pos == 0));
        code = 0;
        if (a == 2'b11) code = 2;
        else if (op && a != 2'b00) code = 1;
        else if (at_end && prev_hold + 1 >= OTL) code = 3;
        else if (m_mode == M_RUN && cmd != 0 && cmd == -m_dir) code = 4;
        if (code != 0) begin
            m_mode = M_FLT;
            m_code = code;
            return;
        end
        case (m_mode)
            M_IDLE: if (cmd != 0) begin
                m_mode = M_SPIN;
                m_dir  = cmd;
                m_spin = ST;
            end
            M_SPIN: if (cmd != m_dir) m_mode = M_IDLE;
                    else begin
                        m_spin--;
                        if (m_spin == 0) m_mode = M_RUN;
                    end
            default: if (cmd == 0) m_mode = M_IDLE;
                     else if (at_end) m_hold = prev_hold + 1;
                     else m_pos += m_dir;
        endcase
    endtask

    task automatic cmp(input string tag, input string what,
                       input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s %s: got %0h expected %0h", tag, what, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [5:0] e_sens;
        e_sens = '0;
        for (int f = 0; f < NF; f++) begin
            if (m_pos - f * T <= Z && f * T - m_pos <= Z) e_sens[f] = 1'b1;
        end
        cmp(tag, "floor_idx", 32'(floor_idx), 32'(m_pos / T));
        cmp(tag, "offset", 32'(offset), 32'(m_pos % T));
        cmp(tag, "sensors", 32'(sensors), 32'(e_sens));
        cmp(tag, "moving", 32'(moving), 32'(m_mode == M_RUN));
        cmp(tag, "fault", 32'(fault), 32'(m_mode == M_FLT));
        cmp(tag, "fault_code", 32'(fault_code), 32'(m_code));
        cmp(tag, "sensors_onehot0", 32'($onehot0(sensors)), 32'd1);
    endtask

    task automatic step(input logic [1:0] a, input logic op, input logic clr, input string tag);
        ac = a;
        open = op;
        fault_clr = clr;
        @(posedge clk);
        model_step(a, op, clr);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #2;
        model_reset();
        check_outputs(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0] r_ac;
        logic       r_open, r_clr;
        ac = 2'b00;
        open = 1'b0;
        fault_clr = 1'b0;
        do_reset("reset");
        cmp("reset", "sensors_const", 32'(sensors), 32'h01);

        // Run up one span from floor 0, then stop at the landing
        for (int i = 0; i < 23; i++) step(2'b01, 1'b0, 1'b0, "t1_up");
        cmp("t1", "floor_const", 32'(floor_idx), 32'd1);
        for (int i = 0; i < 3; i++) step(2'b00, 1'b0, 1'b0, "t2_stop");
        cmp("t2", "sensors_const", 32'(sensors), 32'h02);

        // Drive into the top landing until overtravel trips
        for (int i = 0; i < 200 && m_mode != M_FLT; i++) step(2'b01, 1'b0, 1'b0, "t3_up");
        cmp("t3", "code_const", 32'(fault_code), 32'd3);
        step(2'b00, 1'b0, 1'b1, "t3_clr");
        step(2'b00, 1'b0, 1'b0, "t3_idle");

        // Door open with a drive command
        step(2'b01, 1'b1, 1'b0, "t4_door");
        cmp("t4", "code_const", 32'(fault_code), 32'd1);
        step(2'b01, 1'b0, 1'b1, "t4_clr_ignored");
        step(2'b00, 1'b0, 1'b1, "t4_clr");

        // Direct reversal while running, then reversal during spin-up
        for (int i = 0; i < 10; i++) step(2'b10, 1'b0, 1'b0, "t5_down");
        step(2'b01, 1'b0, 1'b0, "t5_rev_run");
        cmp("t5", "code_const", 32'(fault_code), 32'd4);
        step(2'b00, 1'b0, 1'b1, "t5_clr");
        step(2'b10, 1'b0, 1'b0, "t5_start");
        step(2'b01, 1'b0, 1'b0, "t5_rev_start");
        step(2'b00, 1'b0, 1'b0, "t5_idle");

        // Illegal command
        step(2'b11, 1'b0, 1'b0, "t6_illegal");
        cmp("t6", "code_const", 32'(fault_code), 32'd2);
        step(2'b00, 1'b0, 1'b1, "t6_clr");

        // Random commands that mostly persist, so the car actually travels
        r_ac = 2'b00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                r_ac = ($urandom_range(0, 63) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            end else if (r_ac == 2'b11) begin
                r_ac = 2'b00;
            end
            r_open = $urandom_range(0, 63) == 0;
            r_clr  = $urandom_range(0, 3) == 0;
            step(r_ac, r_open, r_clr, "rand");
        end

        // Reset mid-travel returns the car to floor 0
        step(2'b00, 1'b0, 1'b1, "mid_clr");
        step(2'b00, 1'b0, 1'b0, "mid_idle");
        for (int i = 0; i < 12; i++) step((m_pos >= MAXPOS / 2) ? 2'b10 : 2'b01, 1'b0, 1'b0,
                                         "mid_run");
        do_reset("mid_reset");
        step(2'b00, 1'b0, 1'b0, "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
